// File: rtl/rep5_serial_encoder.sv
// rtl/rep5_serial_encoder.sv - serial repetition-code transmitter, LSB-first, REPEAT copies per bit
module rep5_serial_encoder #(
    parameter int DATA_WIDTH = 8,
    parameter int REPEAT     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  tx_bit,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_first,
    output logic                  tx_copy_last,
    output logic                  tx_frame_last
);

    localparam int REP_W = $clog2(REPEAT);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [REP_W-1:0] REP_TERM = REP_W'(REPEAT - 1);
    localparam logic [BIT_W-1:0] BIT_TERM = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [REP_W-1:0]      rep_cnt_q, rep_cnt_d;

    logic rep_last;
    logic bit_last;

    assign rep_last = (rep_cnt_q == REP_TERM);
    assign bit_last = (bit_cnt_q == BIT_TERM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d   = in_data;
                    bit_cnt_d = '0;
                    rep_cnt_d = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (!rep_last) begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end else if (!bit_last) begin
                        rep_cnt_d = '0;
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        shift_d   = shift_q >> 1;
                    end else begin
                        rep_cnt_d = '0;
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Every output is a decode of registered state only; tx_bit is forced low outside SEND.
    always_comb begin
        in_ready      = (state_q == IDLE);
        tx_valid      = (state_q == SEND);
        tx_bit        = tx_valid & shift_q[0];
        tx_first      = tx_valid & (bit_cnt_q == '0) & (rep_cnt_q == '0);
        tx_copy_last  = tx_valid & rep_last;
        tx_frame_last = tx_valid & rep_last & bit_last;
    end

endmodule

// File: tb/tb_rep5_serial_encoder.sv
// tb/tb_rep5_serial_encoder.sv - directed self-checking bench for rep5_serial_encoder
module tb_rep5_serial_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx_bit;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_first;
    logic       tx_copy_last;
    logic       tx_frame_last;

    int checks = 0;
    int errors = 0;

    rep5_serial_encoder #(.DATA_WIDTH(8), .REPEAT(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .tx_bit       (tx_bit),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_first     (tx_first),
        .tx_copy_last (tx_copy_last),
        .tx_frame_last(tx_frame_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check1({tag, "_in_ready"}, in_ready, 1'b1);
        check1({tag, "_tx_valid"}, tx_valid, 1'b0);
        check1({tag, "_tx_bit"}, tx_bit, 1'b0);
        check1({tag, "_tx_first"}, tx_first, 1'b0);
        check1({tag, "_tx_copy_last"}, tx_copy_last, 1'b0);
        check1({tag, "_tx_frame_last"}, tx_frame_last, 1'b0);
    endtask

    // Sends one word and receives it like the far end: copies grouped by
    // tx_copy_last, optionally corrupted (<=2 per bit), reduced by majority.
    task automatic run_frame(input logic [7:0] word, input bit bp, input int stop_after,
                             input bit keep_valid, input logic [7:0] junk, input bit flip,
                             output int cycles, output logic [7:0] recon);
        int         n;
        int         gi;
        int         bi;
        int         ones;
        logic [4:0] grp;
        logic [4:0] m;
        logic       pb, pf, pc, pl;
        check1("pre_in_ready", in_ready, 1'b1);
        in_data  = word;
        in_valid = 1'b1;
        tx_ready = 1'b0;
        step();
        in_valid = keep_valid;
        in_data  = junk;
        check1("accept_tx_valid", tx_valid, 1'b1);
        check1("accept_tx_first", tx_first, 1'b1);
        check1("accept_in_ready", in_ready, 1'b0);
        n = 0; gi = 0; bi = 0; cycles = 0; recon = '0; grp = '0; m = '0;
        while (n < 40 && n != stop_after && cycles < 1000) begin
            tx_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            check1("send_tx_valid", tx_valid, 1'b1);
            pb = tx_bit; pf = tx_first; pc = tx_copy_last; pl = tx_frame_last;
            if (tx_ready) begin
                check1("tx_bit", tx_bit, word[n / 5]);
                check1("tx_first", tx_first, n == 0);
                check1("tx_copy_last", tx_copy_last, (n % 5) == 4);
                check1("tx_frame_last", tx_frame_last, n == 39);
                if (gi == 0) begin
                    m = '0;
                    if (flip) begin
                        m[$urandom_range(0, 4)] = 1'b1;
                        m[$urandom_range(0, 4)] = 1'b1;
                    end
                end
                grp[gi] = tx_bit ^ m[gi];
                if (tx_copy_last) begin
                    ones = $countones(grp);
                    if (bi < 8) recon[bi] = (ones >= 3);
                    bi++;
                    gi = 0;
                    grp = '0;
                end else begin
                    gi = (gi < 4) ? gi + 1 : 0;
                end
                n++;
            end
            step();
            cycles++;
            if (!tx_ready && n < 40) begin
                check1("hold_tx_valid", tx_valid, 1'b1);
                check1("hold_tx_bit", tx_bit, pb);
                check1("hold_tx_first", tx_first, pf);
                check1("hold_tx_copy_last", tx_copy_last, pc);
                check1("hold_tx_frame_last", tx_frame_last, pl);
            end
        end
        if (stop_after < 0) begin
            check32("transfers", 32'(n), 32'd40);
            check1("end_in_ready", in_ready, 1'b1);
            check1("end_tx_valid", tx_valid, 1'b0);
            check1("end_tx_frame_last", tx_frame_last, 1'b0);
        end
    endtask

    initial begin
        int         cyc;
        logic [7:0] rec;
        logic [7:0] w;

        rst_n    = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        tx_ready = 1'b0;

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        check_idle_outputs("post_reset");

        run_frame(8'hA5, 1'b0, -1, 1'b0, 8'h00, 1'b0, cyc, rec);
        check32("a5_cycles", 32'(cyc), 32'd40);
        check32("a5_word", 32'(rec), 32'hA5);

        run_frame(8'h01, 1'b1, -1, 1'b0, 8'hFE, 1'b0, cyc, rec);
        check32("bp_word", 32'(rec), 32'h01);

        // in_valid stays high and in_data flips to 00 during the FF frame.
        run_frame(8'hFF, 1'b0, -1, 1'b1, 8'h00, 1'b0, cyc, rec);
        check32("b2b_ff_word", 32'(rec), 32'hFF);
        check32("b2b_spacing", 32'(cyc + 1), 32'd41);
        run_frame(8'h00, 1'b0, -1, 1'b0, 8'h00, 1'b0, cyc, rec);
        check32("b2b_00_word", 32'(rec), 32'h00);

        run_frame(8'h3C, 1'b0, 17, 1'b0, 8'h00, 1'b0, cyc, rec);
        check1("midframe_tx_valid_before", tx_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1 check_idle_outputs("midframe_reset");
        #2 rst_n = 1'b1;
        step();
        check_idle_outputs("midframe_release");
        run_frame(8'hC3, 1'b0, -1, 1'b0, 8'h00, 1'b0, cyc, rec);
        check32("c3_word", 32'(rec), 32'hC3);

        for (int i = 0; i < 1000; i++) begin
            w = 8'($urandom);
            run_frame(w, i[0], -1, 1'b0, 8'($urandom), 1'b1, cyc, rec);
            check32("loopback_word", 32'(rec), 32'(w));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
